// File: rtl/cpu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | cpu_pkg : shared widths, reset constants and fetch FSM encoding            |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
package cpu_pkg;

    localparam int          ADDR_W    = 32;
    localparam int          DATA_W    = 32;
    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        HOLD  = 2'd2,
        DROP  = 2'd3
    } fetch_state_t;

endpackage
`default_nettype wire

// File: rtl/fetch_out_slot.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fetch_out_slot : IF/ID output register with load / clear / consume         |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module fetch_out_slot #(
    parameter int                ADDR_W    = cpu_pkg::ADDR_W,
    parameter int                DATA_W    = cpu_pkg::DATA_W,
    parameter logic [DATA_W-1:0] NOP_INSTR = cpu_pkg::NOP_INSTR
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              free,
    input  logic              load,
    input  logic              clear,
    input  logic [ADDR_W-1:0] load_pc,
    input  logic [DATA_W-1:0] load_instr,
    output logic              out_valid,
    output logic [ADDR_W-1:0] out_pc,
    output logic [DATA_W-1:0] out_instr,
    output logic [ADDR_W-1:0] out_pc_plus4
);
    import cpu_pkg::*;

    localparam logic [ADDR_W-1:0] C_FOUR = ADDR_W'(4);

    logic              r_valid;
    logic [ADDR_W-1:0] r_pc;
    logic [DATA_W-1:0] r_instr;
    logic [ADDR_W-1:0] r_pc_plus4;

    // clear beats load; a consumed slot with nothing new keeps pc/instr
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid    <= 1'b0;
            r_pc       <= '0;
            r_instr    <= NOP_INSTR;
            r_pc_plus4 <= C_FOUR;
        end else if (clear) begin
            r_valid    <= 1'b0;
            r_instr    <= NOP_INSTR;
        end else if (load) begin
            r_valid    <= 1'b1;
            r_pc       <= load_pc;
            r_instr    <= load_instr;
            r_pc_plus4 <= load_pc + C_FOUR;
        end else if (free) begin
            r_valid    <= 1'b0;
        end
    end

    assign out_valid    = r_valid;
    assign out_pc       = r_pc;
    assign out_instr    = r_instr;
    assign out_pc_plus4 = r_pc_plus4;

endmodule
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fetch_stage : PC owner, single-outstanding imem fetch, redirect handling   |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module fetch_stage #(
    parameter int                ADDR_W    = cpu_pkg::ADDR_W,
    parameter int                DATA_W    = cpu_pkg::DATA_W,
    parameter logic [ADDR_W-1:0] RESET_PC  = cpu_pkg::RESET_PC,
    parameter logic [DATA_W-1:0] NOP_INSTR = cpu_pkg::NOP_INSTR
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [ADDR_W-1:0] imem_req_addr,
    input  logic              imem_resp_valid,
    input  logic [DATA_W-1:0] imem_resp_data,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    input  logic              stall,
    output logic              out_valid,
    output logic [ADDR_W-1:0] out_pc,
    output logic [DATA_W-1:0] out_instr,
    output logic [ADDR_W-1:0] out_pc_plus4
);
    import cpu_pkg::*;

    localparam logic [ADDR_W-1:0] C_FOUR = ADDR_W'(4);

    fetch_state_t      r_state;
    fetch_state_t      w_next_state;
    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] r_inflight_pc;
    logic [ADDR_W-1:0] r_hold_pc;
    logic [DATA_W-1:0] r_hold_data;
    logic              r_hold_valid;

    logic              w_req_valid;
    logic              w_accept;
    logic              w_free;
    logic              w_load;
    logic [ADDR_W-1:0] w_load_pc;
    logic [DATA_W-1:0] w_load_instr;

    assign w_free   = !out_valid || !stall;
    assign w_accept = w_req_valid && imem_req_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= FETCH;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        if (redirect_valid) begin
            case (r_state)
                // a response landing in the same cycle as a redirect is dropped
                // right here; otherwise wait out the wrong-path response
                WAIT:    w_next_state = imem_resp_valid ? FETCH : DROP;
                DROP:    w_next_state = imem_resp_valid ? FETCH : DROP;
                default: w_next_state = FETCH;
            endcase
        end else begin
            case (r_state)
                FETCH:   if (w_accept)        w_next_state = WAIT;
                WAIT:    if (imem_resp_valid) w_next_state = w_free ? FETCH : HOLD;
                HOLD:    if (w_free)          w_next_state = FETCH;
                DROP:    if (imem_resp_valid) w_next_state = FETCH;
                default:                      w_next_state = FETCH;
            endcase
        end
    end

    always_comb begin
        w_req_valid  = (r_state == FETCH) && !redirect_valid && !rst;
        w_load       = 1'b0;
        w_load_pc    = r_inflight_pc;
        w_load_instr = imem_resp_data;
        if (!redirect_valid && w_free) begin
            case (r_state)
                WAIT: w_load = imem_resp_valid;
                HOLD: begin
                    w_load       = r_hold_valid;
                    w_load_pc    = r_hold_pc;
                    w_load_instr = r_hold_data;
                end
                default: w_load = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc          <= RESET_PC;
            r_inflight_pc <= '0;
            r_hold_pc     <= '0;
            r_hold_data   <= NOP_INSTR;
            r_hold_valid  <= 1'b0;
        end else if (redirect_valid) begin
            r_pc          <= redirect_pc;
            r_hold_valid  <= 1'b0;
        end else begin
            if (w_accept) begin
                r_inflight_pc <= r_pc;
                r_pc          <= r_pc + C_FOUR;
            end
            if ((r_state == WAIT) && imem_resp_valid && !w_free) begin
                r_hold_valid <= 1'b1;
                r_hold_pc    <= r_inflight_pc;
                r_hold_data  <= imem_resp_data;
            end else if ((r_state == HOLD) && w_free) begin
                r_hold_valid <= 1'b0;
            end
        end
    end

    assign imem_req_valid = w_req_valid;
    assign imem_req_addr  = r_pc;

    fetch_out_slot #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .NOP_INSTR (NOP_INSTR)
    ) u_out_slot (
        .clk          (clk),
        .rst          (rst),
        .free         (w_free),
        .load         (w_load),
        .clear        (redirect_valid),
        .load_pc      (w_load_pc),
        .load_instr   (w_load_instr),
        .out_valid    (out_valid),
        .out_pc       (out_pc),
        .out_instr    (out_instr),
        .out_pc_plus4 (out_pc_plus4)
    );

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_fetch_stage : random + directed bench with transaction-level model      |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_fetch_stage;

    localparam logic [31:0] KEY      = 32'hA5A5_0000;
    localparam logic [31:0] NOP      = 32'h0000_0000;
    localparam logic [31:0] RST_PC   = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid = 1'b0;
    logic [31:0] imem_resp_data = '0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        stall = 1'b0;
    logic        out_valid;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic [31:0] out_pc_plus4;

    fetch_stage dut (
        .clk             (clk),
        .rst             (rst),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .stall           (stall),
        .out_valid       (out_valid),
        .out_pc          (out_pc),
        .out_instr       (out_instr),
        .out_pc_plus4    (out_pc_plus4)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // stimulus knobs
    int          p_stall = 0, p_redir = 0, p_nready = 0;
    int          lat_min = 1, lat_max = 1;
    bit          force_stall = 0, force_nready = 0, force_redir = 0, rst_req = 1;
    logic [31:0] force_rpc = '0;
    bit          ideal = 0;

    // reference model: memory with one pending response, expected streams
    int          cyc = 0;
    bit          pend_v = 0;
    logic [31:0] pend_addr = '0;
    int          pend_due = 0;
    logic [31:0] exp_fetch = RST_PC;
    logic [31:0] exp_out = RST_PC;
    int          in_flight = 0;
    int          last_cons = -1;
    int          idle = 0;
    bit          seen_wrap = 0;
    bit          acc_flag = 0;
    logic [31:0] last_acc_addr = '0;

    bit          prev_rst = 1, prev_redir = 0, prev_ov = 0, prev_stall = 0;
    bit          prev_rv = 0, prev_ready = 0;
    logic [31:0] prev_pc = '0, prev_instr = '0, prev_addr = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic tick();
        bit acc, cons;
        @(negedge clk);
        rst            = rst_req;
        stall          = force_stall || ($urandom_range(99) < p_stall);
        imem_req_ready = !force_nready && !($urandom_range(99) < p_nready);
        if (force_redir) begin
            redirect_valid = 1'b1;
            redirect_pc    = force_rpc;
            force_redir    = 1'b0;
        end else begin
            redirect_valid = ($urandom_range(99) < p_redir);
            redirect_pc    = $urandom & 32'hFFFF_FFFC;
        end
        imem_resp_valid = pend_v && (pend_due == cyc);
        imem_resp_data  = imem_resp_valid ? (pend_addr ^ KEY) : $urandom;
        #1;
        acc      = imem_req_valid && imem_req_ready;
        acc_flag = acc;
        if (acc) last_acc_addr = imem_req_addr;
        if (imem_resp_valid) pend_v = 0;
        if (rst) begin
            check("req_in_reset", 32'(imem_req_valid), 32'd0);
            exp_fetch = RST_PC;
            exp_out   = RST_PC;
            in_flight = 0;
        end else begin
            if (!prev_rst) begin
                if (prev_redir) begin
                    check("flush_valid", 32'(out_valid), 32'd0);
                    check("flush_instr", out_instr, NOP);
                end else if (prev_ov && prev_stall) begin
                    check("held_valid", 32'(out_valid), 32'd1);
                    check("held_pc", out_pc, prev_pc);
                    check("held_instr", out_instr, prev_instr);
                end
                if (prev_rv && !prev_ready && !prev_redir) begin
                    check("req_addr_stable", imem_req_addr, prev_addr);
                    if (!redirect_valid) check("req_valid_stable", 32'(imem_req_valid), 32'd1);
                end
            end
            if (redirect_valid) check("req_during_redirect", 32'(imem_req_valid), 32'd0);
            if (out_valid) check("pc_plus4", out_pc_plus4, out_pc + 32'd4);
            cons = out_valid && !stall && !redirect_valid;
            if (cons) begin
                check("out_pc", out_pc, exp_out);
                check("out_instr", out_instr, exp_out ^ KEY);
                if (ideal && last_cons >= 0) check("out_gap", 32'(cyc - last_cons), 32'd2);
                if (out_pc == 32'hFFFF_FFFC && out_pc_plus4 == 32'd0) seen_wrap = 1;
                last_cons = cyc;
                exp_out   = exp_out + 32'd4;
                in_flight--;
                idle = 0;
            end else begin
                idle++;
            end
            if (acc) begin
                check("req_addr", imem_req_addr, exp_fetch);
                check("single_outstanding", 32'(pend_v), 32'd0);
                pend_v    = 1;
                pend_addr = imem_req_addr;
                pend_due  = cyc + int'($urandom_range(lat_max, lat_min));
                exp_fetch = exp_fetch + 32'd4;
                in_flight++;
            end
            if (redirect_valid) begin
                exp_fetch = redirect_pc;
                exp_out   = redirect_pc;
                in_flight = 0;
            end
            check("fetch_depth", 32'(in_flight <= 2), 32'd1);
            if (idle > 200) begin
                check("progress", 32'd0, 32'd1);
                idle = 0;
            end
        end
        prev_rst   = rst;
        prev_redir = redirect_valid;
        prev_ov    = out_valid;
        prev_stall = stall;
        prev_rv    = imem_req_valid;
        prev_ready = imem_req_ready;
        prev_pc    = out_pc;
        prev_instr = out_instr;
        prev_addr  = imem_req_addr;
        cyc++;
    endtask

    task automatic wait_accept(input string tag);
        int n = 0;
        tick();
        while (!acc_flag && n < 30) begin
            tick();
            n++;
        end
        check(tag, 32'(acc_flag), 32'd1);
    endtask

    task automatic set_ideal();
        p_stall = 0; p_redir = 0; p_nready = 0;
        lat_min = 1; lat_max = 1;
        ideal = 1; last_cons = -1;
    endtask

    initial begin
        logic [31:0] a0;
        int n;
        // reset
        rst_req = 1;
        repeat (3) tick();
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_pc", out_pc, 32'd0);
        check("rst_out_instr", out_instr, NOP);
        check("rst_pc_plus4", out_pc_plus4, 32'd4);
        check("rst_req_addr", imem_req_addr, RST_PC);
        rst_req = 0;

        // straight-line fetch, 1-cycle memory
        set_ideal();
        repeat (14) tick();

        // long stall while a response arrives
        n = 0;
        while (!out_valid && n < 10) begin tick(); n++; end
        ideal = 0;
        force_stall = 1;
        repeat (6) tick();
        check("hold_no_req", 32'(imem_req_valid), 32'd0);
        check("hold_out_valid", 32'(out_valid), 32'd1);
        force_stall = 0;
        tick();
        tick();
        check("hold_released", 32'(out_valid), 32'd1);
        repeat (6) tick();

        // redirect while waiting, wrong-path response two cycles later
        lat_min = 3; lat_max = 3;
        wait_accept("wait_acc_d");
        force_redir = 1; force_rpc = 32'h0000_0100;
        tick();
        n = 0;
        tick();
        while (!acc_flag && n < 20) begin
            check("drop_out_valid", 32'(out_valid), 32'd0);
            tick();
            n++;
        end
        check("redirect_target", last_acc_addr, 32'h0000_0100);
        repeat (8) tick();

        // redirect together with the response
        lat_min = 1; lat_max = 1;
        wait_accept("wait_acc_e");
        force_redir = 1; force_rpc = 32'h0000_0200;
        tick();
        check("redir_resp_req", 32'(imem_req_valid), 32'd0);
        tick();
        check("refetch_valid", 32'(imem_req_valid), 32'd1);
        check("refetch_addr", imem_req_addr, 32'h0000_0200);
        repeat (6) tick();

        // memory not ready for four cycles
        force_nready = 1;
        tick();
        a0 = imem_req_addr;
        repeat (3) tick();
        check("nready_addr", imem_req_addr, a0);
        force_nready = 0;
        repeat (6) tick();

        // PC wrap
        ideal = 0;
        force_redir = 1; force_rpc = 32'hFFFF_FFF8;
        tick();
        set_ideal();
        repeat (16) tick();
        check("wrap_seen", 32'(seen_wrap), 32'd1);

        // reset mid-WAIT with a stalled valid output
        ideal = 0;
        lat_min = 3; lat_max = 3;
        force_stall = 1;
        n = 0;
        tick();
        while (!(out_valid && acc_flag) && n < 40) begin tick(); n++; end
        check("rst_setup", 32'(out_valid && acc_flag), 32'd1);
        rst_req = 1;
        tick();
        rst_req = 0;
        force_nready = 1;
        tick();
        check("rst2_out_valid", 32'(out_valid), 32'd0);
        check("rst2_out_instr", out_instr, NOP);
        check("rst2_req_addr", imem_req_addr, RST_PC);
        tick();
        tick();
        check("late_resp_ignored", 32'(out_valid), 32'd0);
        force_nready = 0;
        force_stall  = 0;
        set_ideal();
        repeat (10) tick();

        // random traffic
        ideal = 0;
        p_stall = 30; p_redir = 4; p_nready = 25;
        lat_min = 1; lat_max = 3;
        repeat (3000) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
